alu_seq: RTL and testbench
==========================

# alu_seq

Pipelined request/response wrapper around the combinational `alu`. It accepts one operation per cycle over a valid/ready handshake and registers the operands. The existing `alu` computes the result, which is then buffered with its flags in a small result FIFO for a downstream consumer. It also maintains a sticky signed-overflow flag and a saturating operation counter. It is the responder side of the ALU operand interface, used by the multi-cycle CPU datapath and by the system-level bench in place of direct combinational driving.

## Interface
Parameters:
- `DEPTH`, 4: result FIFO entries; power of two, minimum 2.
- `TAGW`, 4: width of the transaction tag carried from request to response.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request can be accepted this cycle.
- `req_a` in 32: operand a.
- `req_b` in 32: operand b.
- `req_aluc` in 4: ALU op code, passed unchanged to `alu`.
- `req_tag` in TAGW: transaction tag.
- `rsp_valid` out 1: response present at FIFO head.
- `rsp_ready` in 1: consumer accepts response.
- `rsp_r` out 32: result.
- `rsp_zero`, `rsp_carry`, `rsp_negative`, `rsp_overflow` out 1 each: ALU flags.
- `rsp_tag` out TAGW: tag of the request that produced this response.
- `clr_sticky` in 1: clear sticky overflow.
- `sticky_ovf` out 1: a signed add/sub overflowed since the last clear or reset.
- `op_count` out 16: completed operations, saturating.

## Operation
- Request accepted when `req_valid && req_ready` at a rising edge. `a`, `b`, `aluc` and `tag` are latched into the operand stage, and `stg_v` is set.
- The operand-stage registers drive `alu` directly; there is no combinational path from `req_*` to `alu`.
- When `stg_v = 1`, the next edge writes `{r, zero, carry, negative, overflow, tag}` into the FIFO tail and clears `stg_v`, unless a new request is accepted in the same cycle.
- `req_ready = (stg_v + fifo_count) < DEPTH`.
  - Computed from registers only; it never depends on `rsp_ready`.
  - This credit check guarantees the FIFO write can never overflow.
- A response pops when `rsp_valid && rsp_ready`. Push and pop in the same cycle leave `fifo_count` unchanged.
- `rsp_*` is driven from the FIFO head. Payload is don't-care while `rsp_valid = 0`.
- `sticky_ovf` is set on a FIFO write whose overflow flag is 1 and whose `aluc` is 4'b0010 (add) or 4'b0011 (sub).
  - Other ops never set it.
  - Same-cycle set and `clr_sticky`: set wins.
- `op_count` increments on each FIFO write and holds at 16'hFFFF.
- Order is preserved: responses leave in request order.

## Timing
- Reset values: `req_ready` = 1, `rsp_valid` = 0, `sticky_ovf` = 0, `op_count` = 0, `stg_v` = 0, FIFO empty, FIFO pointers 0, response payload 0.
- Latency: request accepted at edge N gives a response written at edge N+1, with `rsp_valid` = 1 from edge N+1 onward. That is one cycle from acceptance, minimum two edges between request presentation and response pop.
- Throughput: one op per cycle while `rsp_ready` is held high (`DEPTH` ≥ 2 keeps `req_ready` high at steady-state occupancy 2).
- Full: `req_ready` = 0 once `stg_v + count = DEPTH`. It returns to 1 the cycle after a pop reduces occupancy.
- Empty: `rsp_valid` = 0. A push into an empty FIFO is visible at the next edge; there is no bypass.
- FIFO pointers wrap modulo `DEPTH`. `count` ranges 0..`DEPTH`.
- Reset mid-operation flushes the operand stage and all FIFO contents, with no response produced. `rst` overrides `clr_sticky` and every handshake.

## Structure
- Shared package `alu_pkg`:
  - aluc constants `ALUC_ADDU`=4'b0000, `ALUC_ADD`=4'b0010, `ALUC_SUBU`=4'b0001, `ALUC_SUB`=4'b0011.
  - Response record layout width = 36 + TAGW.
- Sub-module `alu_rsp_fifo`: synchronous FIFO parameterised by `DEPTH` and width, exposing `count`.
- Instantiates the existing `alu` unchanged.

## Test plan
- Addu: `a`=32'h00000010, `b`=32'h80000000, `aluc`=4'b0000, tag 1. Expect `rsp_r`=32'h80000010, `negative`=1, `zero`=0, `rsp_tag`=1, `rsp_valid` one cycle after acceptance, `op_count`=1.
- Add overflow: `a`=32'h7FFFFFFF, `b`=1, `aluc`=4'b0010. Expect `rsp_r`=32'h80000000, `overflow`=1, `sticky_ovf`=1 after the write.
  - Same operands with `aluc`=4'b0000 leave `sticky_ovf`=0.
  - `clr_sticky` pulse clears it.
- Zero: `a`=`b`=5, `aluc`=4'b0011. Expect `rsp_r`=0, `zero`=1, `overflow`=0.
- Backpressure: `rsp_ready`=0, `req_valid` held with tags 0..5.
  - Exactly 4 accepted, then `req_ready`=0.
  - Raising `rsp_ready` returns tags 0,1,2,3 then 4,5 in order, with no loss or duplication.
- Streaming: 100 back-to-back requests with `rsp_ready`=1. `req_ready` never drops and responses arrive one per cycle, in order.
- Reset mid-burst: `rst` asserted with 3 responses pending. Next cycle `rsp_valid`=0, `req_ready`=1, `op_count`=0, `sticky_ovf`=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its pipelined request/response wrapper.
//   - ALU opcode constants (aluc encodings understood by alu)
//   - data/opcode widths and the response record width
//   - helper identifying the signed add/sub opcodes that feed the sticky flag
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int ALUC_W = 4;

  localparam logic [ALUC_W-1:0] ALUC_ADDU = 4'b0000;
  localparam logic [ALUC_W-1:0] ALUC_SUBU = 4'b0001;
  localparam logic [ALUC_W-1:0] ALUC_ADD  = 4'b0010;
  localparam logic [ALUC_W-1:0] ALUC_SUB  = 4'b0011;
  localparam logic [ALUC_W-1:0] ALUC_AND  = 4'b0100;
  localparam logic [ALUC_W-1:0] ALUC_OR   = 4'b0101;
  localparam logic [ALUC_W-1:0] ALUC_XOR  = 4'b0110;
  localparam logic [ALUC_W-1:0] ALUC_NOR  = 4'b0111;
  localparam logic [ALUC_W-1:0] ALUC_LUI  = 4'b1000;
  localparam logic [ALUC_W-1:0] ALUC_SLTU = 4'b1010;
  localparam logic [ALUC_W-1:0] ALUC_SLT  = 4'b1011;
  localparam logic [ALUC_W-1:0] ALUC_SRA  = 4'b1100;
  localparam logic [ALUC_W-1:0] ALUC_SRL  = 4'b1101;
  localparam logic [ALUC_W-1:0] ALUC_SLL  = 4'b1110;

  // Response record: {r[31:0], zero, carry, negative, overflow, tag[TAGW-1:0]}
  function automatic int rsp_width(input int tagw);
    return DATA_W + 4 + tagw;
  endfunction

  // Only the signed add/sub opcodes report a meaningful signed overflow.
  function automatic logic is_signed_addsub(input logic [ALUC_W-1:0] aluc);
    return (aluc == ALUC_ADD) || (aluc == ALUC_SUB);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// ALU operand interface: valid/ready request channel carrying operands, opcode
// and tag; valid/ready response channel carrying result, flags and tag.
//   master : requester / response consumer (CPU datapath, bench)
//   slave  : responder (alu_seq)
interface alu_seq_if
  import alu_pkg::*;
#(
  parameter int TAGW = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [ALUC_W-1:0] req_aluc;
  logic [TAGW-1:0]   req_tag;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_r;
  logic              rsp_zero;
  logic              rsp_carry;
  logic              rsp_negative;
  logic              rsp_overflow;
  logic [TAGW-1:0]   rsp_tag;

  modport master (
    output req_valid, req_a, req_b, req_aluc, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_r, rsp_zero, rsp_carry, rsp_negative,
           rsp_overflow, rsp_tag
  );

  modport slave (
    input  req_valid, req_a, req_b, req_aluc, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_r, rsp_zero, rsp_carry, rsp_negative,
           rsp_overflow, rsp_tag
  );
endinterface

// File: rtl/alu.sv
// Combinational 32-bit ALU.
//   a, b     : operands (shift ops shift b by a[4:0])
//   aluc     : opcode (see alu_pkg)
//   r        : result
//   zero     : r == 0
//   carry    : unsigned carry-out (add) / borrow (sub, sltu)
//   negative : r[31]
//   overflow : signed overflow, only for the signed add/sub opcodes
module alu
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [ALUC_W-1:0] aluc,
  output logic [DATA_W-1:0] r,
  output logic              zero,
  output logic              carry,
  output logic              negative,
  output logic              overflow
);
  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    r        = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (aluc)
      ALUC_ADDU: begin r = sum[DATA_W-1:0];  carry = sum[DATA_W];  end
      ALUC_ADD: begin
        r        = sum[DATA_W-1:0];
        carry    = sum[DATA_W];
        overflow = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      ALUC_SUBU: begin r = diff[DATA_W-1:0]; carry = diff[DATA_W]; end
      ALUC_SUB: begin
        r        = diff[DATA_W-1:0];
        carry    = diff[DATA_W];
        overflow = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      ALUC_AND:  r = a & b;
      ALUC_OR:   r = a | b;
      ALUC_XOR:  r = a ^ b;
      ALUC_NOR:  r = ~(a | b);
      ALUC_LUI, 4'b1001: r = {b[15:0], 16'h0000};
      ALUC_SLTU: begin r = {31'b0, a < b}; carry = a < b; end
      ALUC_SLT:  r = {31'b0, $signed(a) < $signed(b)};
      ALUC_SRA:  r = DATA_W'($signed(b) >>> a[4:0]);
      ALUC_SRL:  r = b >> a[4:0];
      ALUC_SLL, 4'b1111: r = b << a[4:0];
      default:   r = '0;
    endcase
  end

  assign zero     = (r == '0);
  assign negative = r[DATA_W-1];

endmodule

// File: rtl/alu_rsp_fifo.sv
// Synchronous result FIFO.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push/din : write din at the tail (caller guarantees space)
//   pop      : remove the head entry (ignored while empty)
//   dout     : head entry, no bypass from din
//   empty    : count == 0
//   count    : occupancy, 0..DEPTH
module alu_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;

  assign pop_ok = pop && !empty;
  assign empty  = (count == '0);
  assign dout   = mem[rd_ptr];

  // NOTE: the storage array is not reset; only pointers and count are.
  // Stale entries are unreachable because valid is derived from count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers are AW bits wide, so +1 wraps modulo DEPTH (a power of two).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Pipelined request/response wrapper around alu.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : alu_seq_if slave (request in, response out)
//   clr_sticky : clear the sticky signed-overflow flag
//   sticky_ovf : a signed add/sub overflowed since last clear/reset
//   op_count   : completed operations, saturating at 16'hFFFF
// Request -> operand stage (registered) -> alu -> result FIFO -> response.
module alu_seq
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAGW  = 4
) (
  input  logic        clk,
  input  logic        rst,
  alu_seq_if.slave    bus,
  input  logic        clr_sticky,
  output logic        sticky_ovf,
  output logic [15:0] op_count
);
  localparam int RW = rsp_width(TAGW);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              stg_v;
  logic [DATA_W-1:0] stg_a;
  logic [DATA_W-1:0] stg_b;
  logic [ALUC_W-1:0] stg_aluc;
  logic [TAGW-1:0]   stg_tag;

  logic [DATA_W-1:0] alu_r;
  logic              alu_zero, alu_carry, alu_negative, alu_overflow;

  logic              accept, push, pop, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       occupancy;
  logic [RW-1:0]     fifo_din, fifo_dout, rsp_word;

  // Credit check from registers only: stage + FIFO can never exceed DEPTH,
  // so the unconditional push below never overflows the FIFO.
  assign occupancy     = {{CW{1'b0}}, stg_v} + {1'b0, fifo_count};
  assign bus.req_ready = occupancy < (CW+1)'(DEPTH);
  assign accept        = bus.req_valid && bus.req_ready;
  assign push          = stg_v;
  assign pop           = bus.rsp_valid && bus.rsp_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_v    <= 1'b0;
      stg_a    <= '0;
      stg_b    <= '0;
      stg_aluc <= '0;
      stg_tag  <= '0;
    end else if (accept) begin
      stg_v    <= 1'b1;
      stg_a    <= bus.req_a;
      stg_b    <= bus.req_b;
      stg_aluc <= bus.req_aluc;
      stg_tag  <= bus.req_tag;
    end else begin
      stg_v    <= 1'b0;
    end
  end

  alu u_alu (
    .a        (stg_a),
    .b        (stg_b),
    .aluc     (stg_aluc),
    .r        (alu_r),
    .zero     (alu_zero),
    .carry    (alu_carry),
    .negative (alu_negative),
    .overflow (alu_overflow)
  );

  assign fifo_din = {alu_r, alu_zero, alu_carry, alu_negative, alu_overflow, stg_tag};

  alu_rsp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Payload reads as zero while empty, which also gives the reset value.
  assign bus.rsp_valid = !fifo_empty;
  assign rsp_word      = fifo_empty ? '0 : fifo_dout;
  assign {bus.rsp_r, bus.rsp_zero, bus.rsp_carry, bus.rsp_negative,
          bus.rsp_overflow, bus.rsp_tag} = rsp_word;

  // A set in the same cycle as clr_sticky takes priority.
  always_ff @(posedge clk) begin
    if (rst)
      sticky_ovf <= 1'b0;
    else if (push && alu_overflow && is_signed_addsub(stg_aluc))
      sticky_ovf <= 1'b1;
    else if (clr_sticky)
      sticky_ovf <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      op_count <= '0;
    else if (push && (op_count != 16'hFFFF))
      op_count <= op_count + 16'd1;
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed ALU cases, sticky flag behaviour,
// backpressure, streaming throughput and reset mid-burst. Expected responses
// come from an independent arithmetic model pushed to a scoreboard queue on
// acceptance and compared when the response pops.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAGW  = 4;

  typedef struct {
    logic [31:0]     r;
    logic            z;
    logic            c;
    logic            n;
    logic            v;
    logic [TAGW-1:0] tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_sticky;
  logic        sticky_ovf;
  logic [15:0] op_count;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  exp_t mon_e;

  alu_seq_if #(.TAGW(TAGW)) bus ();

  alu_seq #(
    .DEPTH (DEPTH),
    .TAGW  (TAGW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .clr_sticky (clr_sticky),
    .sticky_ovf (sticky_ovf),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model for the opcodes used here, computed with 64-bit arithmetic.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] op, input logic [TAGW-1:0] tag);
    exp_t   e;
    longint ua, ub, us, sa, sb_, ss;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    e.c = 1'b0;
    e.v = 1'b0;
    e.r = '0;
    if (op == ALUC_ADDU || op == ALUC_ADD) begin
      us  = ua + ub;
      ss  = sa + sb_;
      e.r = us[31:0];
      e.c = us[32];
      if (op == ALUC_ADD) e.v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    end else if (op == ALUC_SUBU || op == ALUC_SUB) begin
      us  = ua - ub;
      ss  = sa - sb_;
      e.r = us[31:0];
      e.c = (ua < ub);
      if (op == ALUC_SUB) e.v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    end else if (op == ALUC_AND) begin
      e.r = a & b;
    end
    e.z   = (e.r == 32'h0);
    e.n   = e.r[31];
    e.tag = tag;
    return e;
  endfunction

  // Monitor: sampled on the falling edge, i.e. the values the next rising
  // edge will act on.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (bus.req_valid && bus.req_ready)
        sb.push_back(model(bus.req_a, bus.req_b, bus.req_aluc, bus.req_tag));
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("rsp_r",        bus.rsp_r,        mon_e.r);
          check("rsp_zero",     bus.rsp_zero,     mon_e.z);
          check("rsp_carry",    bus.rsp_carry,    mon_e.c);
          check("rsp_negative", bus.rsp_negative, mon_e.n);
          check("rsp_overflow", bus.rsp_overflow, mon_e.v);
          check("rsp_tag",      bus.rsp_tag,      mon_e.tag);
        end
      end
    end
  end

  // Present one request and hold it until accepted; returns 1ns after the
  // accepting edge with req_valid dropped.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                      input logic [TAGW-1:0] tag, output int stalls);
    logic ok;
    ok           = 1'b0;
    stalls       = 0;
    bus.req_a    = a;
    bus.req_b    = b;
    bus.req_aluc = op;
    bus.req_tag  = tag;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
      stalls++;
    end
    if (!ok) check("req_accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    check("drain_empty", sb.size(), 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int total_stalls;
    int n_acc;
    logic [3:0] ops [5];
    ops[0] = ALUC_ADDU; ops[1] = ALUC_ADD; ops[2] = ALUC_SUBU;
    ops[3] = ALUC_SUB;  ops[4] = ALUC_AND;

    rst           = 1'b1;
    clr_sticky    = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_aluc  = '0;
    bus.req_tag   = '0;
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("reset_req_ready",  bus.req_ready, 1);
    check("reset_rsp_valid",  bus.rsp_valid, 0);
    check("reset_sticky",     sticky_ovf,    0);
    check("reset_op_count",   op_count,      0);
    check("reset_rsp_r",      bus.rsp_r,     0);
    check("reset_rsp_tag",    bus.rsp_tag,   0);

    // Addu with latency: response visible one edge after acceptance
    send(32'h0000_0010, 32'h8000_0000, ALUC_ADDU, 4'd1, st);
    check("addu_valid_at_accept", bus.rsp_valid, 0);
    tick();
    check("addu_valid_next",  bus.rsp_valid, 1);
    check("addu_negative",    bus.rsp_negative, 1);
    check("addu_r",           bus.rsp_r, 32'h8000_0010);
    check("addu_op_count",    op_count, 1);

    // Signed add overflow sets sticky on the FIFO write
    send(32'h7FFF_FFFF, 32'h1, ALUC_ADD, 4'd2, st);
    check("add_sticky_before_write", sticky_ovf, 0);
    tick();
    check("add_sticky_set",   sticky_ovf, 1);
    check("add_op_count",     op_count, 2);

    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    check("sticky_cleared",   sticky_ovf, 0);

    // Same operands, unsigned add: sticky stays clear
    send(32'h7FFF_FFFF, 32'h1, ALUC_ADDU, 4'd3, st);
    tick();
    check("addu_no_sticky",   sticky_ovf, 0);

    // Zero result
    send(32'd5, 32'd5, ALUC_SUB, 4'd4, st);
    tick();
    check("sub_zero_no_sticky", sticky_ovf, 0);

    // Sub overflow while clr_sticky held: set wins
    clr_sticky = 1'b1;
    send(32'h8000_0000, 32'h1, ALUC_SUB, 4'd5, st);
    tick();
    check("sticky_set_wins",  sticky_ovf, 1);
    check("op_count_5",       op_count, 5);
    clr_sticky = 1'b0;
    drain();

    // Backpressure: hold requests with the consumer stalled
    bus.rsp_ready = 1'b0;
    n_acc         = 0;
    bus.req_a     = 32'd0;
    bus.req_b     = 32'd100;
    bus.req_aluc  = ALUC_ADDU;
    bus.req_tag   = 4'd0;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.req_ready) n_acc++;
      tick();
      bus.req_a   = 32'(n_acc);
      bus.req_tag = 4'(n_acc);
    end
    bus.req_valid = 1'b0;
    check("bp_accepted",      n_acc, 4);
    check("bp_req_ready_low", bus.req_ready, 0);
    check("bp_rsp_valid",     bus.rsp_valid, 1);
    bus.rsp_ready = 1'b1;
    tick();
    check("bp_ready_after_pop", bus.req_ready, 1);
    send(32'd4, 32'd100, ALUC_ADDU, 4'd4, st);
    send(32'd5, 32'd100, ALUC_ADDU, 4'd5, st);
    drain();

    // Streaming: 100 back-to-back requests, consumer always ready
    total_stalls = 0;
    for (int i = 0; i < 100; i++) begin
      send($urandom, $urandom, ops[$urandom_range(0, 4)], 4'(i), st);
      total_stalls += st;
    end
    check("stream_stalls",    total_stalls, 0);
    check("stream_backlog",   sb.size(), 2);
    check("stream_rsp_valid", bus.rsp_valid, 1);
    drain();

    // Reset mid-burst with three responses pending
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    bus.rsp_ready = 1'b0;
    send(32'h7FFF_FFFF, 32'h1, ALUC_ADD, 4'd7, st);
    send(32'd9, 32'd3, ALUC_SUBU, 4'd8, st);
    send(32'hF0F0_F0F0, 32'hFF00_FF00, ALUC_AND, 4'd9, st);
    tick();
    check("pre_reset_rsp_valid", bus.rsp_valid, 1);
    check("pre_reset_sticky",    sticky_ovf, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_reset_rsp_valid", bus.rsp_valid, 0);
    check("mid_reset_req_ready", bus.req_ready, 1);
    check("mid_reset_op_count",  op_count, 0);
    check("mid_reset_sticky",    sticky_ovf, 0);
    check("mid_reset_rsp_r",     bus.rsp_r, 0);

    // Operation resumes cleanly after reset
    bus.rsp_ready = 1'b1;
    send(32'h1234_0000, 32'h0000_5678, ALUC_ADDU, 4'd3, st);
    tick();
    check("post_reset_op_count", op_count, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
